cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001: Parameter WORDS_PER_LINE, default 8; words per cache line and beats per higher-memory line transfer.
REQ-002: Parameter READ_ONLY, default 0; when 1 the block has no store path, no dirty tracking and no writeback.
REQ-003: clk  in  1  sole clock, all state on posedge.
REQ-004: reset  in  1  asynchronous, active-high.
REQ-005: req_valid  in  1  requester holds high with stable address/operation until req_fulfilled.
REQ-006: req_operation  in  1  0=LOAD, 1=STORE; treated as LOAD when READ_ONLY=1.
REQ-007: req_fulfilled  out  1  single-cycle completion pulse to requester.
REQ-008: hmem_req_valid  out  1  beat request to higher memory.
REQ-009: hmem_req_operation  out  1  0=LOAD, 1=STORE.
REQ-010: hmem_req_fulfilled  in  1  higher memory completes the current beat this cycle.
REQ-011: valid_block_match, valid_dirty_bit, counter_done  in  1 each  datapath status.
REQ-012: miss_recovery_mode, perform_write, set_selected_dirty_bit, clear_selected_dirty_bit, clear_selected_valid_bit, finish_new_line_install, set_hmem_block_address, use_victim_tag_for_hmem_block_address, reset_counter, decrement_counter  out  1 each  datapath controls, all Moore/Mealy decoded from state and inputs.

Function
REQ-013: FSM states: IDLE, LOOKUP, WRITEBACK, ALLOCATE; encoding is free.
REQ-014: IDLE: all outputs 0; req_valid=1 -> LOOKUP next cycle.
REQ-015: LOOKUP, req_valid=0: -> IDLE, no side effects.
REQ-016: LOOKUP hit (valid_block_match=1), LOAD: req_fulfilled=1 -> IDLE.
REQ-017: LOOKUP hit, STORE: perform_write=1, set_selected_dirty_bit=1, req_fulfilled=1 -> IDLE.
REQ-018: LOOKUP miss, valid_dirty_bit=1 and READ_ONLY=0: set_hmem_block_address=1, use_victim_tag_for_hmem_block_address=1, reset_counter=1 -> WRITEBACK.
REQ-019: LOOKUP miss otherwise: set_hmem_block_address=1, use_victim_tag=0, reset_counter=1, clear_selected_valid_bit=1 -> ALLOCATE.
REQ-020: WRITEBACK: miss_recovery_mode=1, hmem_req_valid=1, hmem_req_operation=STORE every cycle in state.
REQ-021: WRITEBACK, hmem_req_fulfilled=1, counter_done=0: decrement_counter=1, stay.
REQ-022: WRITEBACK, hmem_req_fulfilled=1, counter_done=1: clear_selected_dirty_bit=1, clear_selected_valid_bit=1, set_hmem_block_address=1 (use_victim=0), reset_counter=1 -> ALLOCATE.
REQ-023: ALLOCATE: miss_recovery_mode=1, hmem_req_valid=1, hmem_req_operation=LOAD every cycle in state.
REQ-024: ALLOCATE, hmem_req_fulfilled=1: perform_write=1; counter_done=0 -> decrement_counter=1, stay; counter_done=1 -> finish_new_line_install=1, -> LOOKUP (replay, guaranteed hit).
REQ-025: hmem_req_fulfilled=0 in WRITEBACK/ALLOCATE: hold state, no counter/write/metadata pulses.
REQ-026: Miss latency: 1 (LOOKUP) + N beats + 1 (replay LOOKUP); N=WORDS_PER_LINE clean, 2*WORDS_PER_LINE dirty.
REQ-027: req_valid dropping in WRITEBACK/ALLOCATE is ignored; line transfer completes, replay LOOKUP then returns to IDLE per REQ-015.
REQ-028: READ_ONLY=1: WRITEBACK unreachable; set_selected_dirty_bit, clear_selected_dirty_bit, use_victim_tag, perform_write outside ALLOCATE tied 0.
REQ-029: req_fulfilled never asserted outside LOOKUP; never two consecutive cycles.
REQ-030: Exactly one of perform_write source paths active per cycle; hmem_req_valid=0 in IDLE/LOOKUP.

Reset
REQ-031: reset=1 forces IDLE asynchronously; all outputs 0 while asserted and first cycle after release.
REQ-032: reset mid-WRITEBACK/ALLOCATE abandons the transfer; no further hmem_req_valid until a new miss.

Verification
REQ-033: LOAD hit: req_valid=1, valid_block_match=1 -> req_fulfilled at cycle 2, no hmem activity.
REQ-034: STORE hit -> perform_write, set_selected_dirty_bit, req_fulfilled all 1 in same cycle, then IDLE.
REQ-035: Clean LOAD miss, WORDS_PER_LINE=8, hmem fulfils every cycle -> 8 LOAD beats, 7 decrement_counter, finish_new_line_install on beat 8, req_fulfilled on cycle 11.
REQ-036: Dirty STORE miss, fulfil every other cycle -> 8 STORE beats with use_victim_tag at LOOKUP, then 8 LOAD beats, then hit write; req_fulfilled once.
REQ-037: reset asserted on ALLOCATE beat 4 -> outputs 0 immediately, state IDLE, later req_valid restarts at LOOKUP.
REQ-038: READ_ONLY=1, miss with valid_dirty_bit=1 -> goes directly to ALLOCATE, no STORE beat ever issued.

Source files
------------

// File: rtl/cache_controller_if.sv
// ---------------------------------------------------------------------------
// cache_controller_if
//   Bus bundle between the cache controller, its requester and the higher
//   memory. Only the handshake signals are carried here. The datapath
//   status and control strobes stay as plain ports on the controller.
//
//   Requester side  : req_valid, req_operation (0=LOAD, 1=STORE), req_fulfilled
//   Higher memory   : hmem_req_valid, hmem_req_operation (0=LOAD, 1=STORE),
//                     hmem_req_fulfilled
//
//   modport slave  : the controller. It serves the requester and drives the
//                    higher-memory beat requests.
//   modport master : the environment. It is the requester plus the higher
//                    memory.
// ---------------------------------------------------------------------------
interface cache_controller_if;
  logic req_valid;
  logic req_operation;
  logic req_fulfilled;
  logic hmem_req_valid;
  logic hmem_req_operation;
  logic hmem_req_fulfilled;

  modport slave (
    input  req_valid,
    input  req_operation,
    input  hmem_req_fulfilled,
    output req_fulfilled,
    output hmem_req_valid,
    output hmem_req_operation
  );

  modport master (
    output req_valid,
    output req_operation,
    output hmem_req_fulfilled,
    input  req_fulfilled,
    input  hmem_req_valid,
    input  hmem_req_operation
  );
endinterface

// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//   Control FSM for a blocking, single-requester cache. A request is looked
//   up first. A hit completes in the lookup cycle. A miss evicts a dirty
//   victim line when one exists (WRITEBACK), then fetches the new line
//   (ALLOCATE). After that the request is replayed as a lookup, which is
//   then guaranteed to hit. One line transfer is WORDS_PER_LINE beats, each
//   beat completed by hmem_req_fulfilled.
//
//   Parameters
//     WORDS_PER_LINE : words per line = beats per line transfer
//     READ_ONLY      : 1 removes the store path, dirty tracking and writeback
//
//   Ports
//     clk, reset                  : clock, asynchronous active-high reset
//     bus (slave)                 : requester / higher-memory handshakes
//     valid_block_match           : lookup hit status from the tag array
//     valid_dirty_bit             : selected victim is valid and dirty
//     counter_done                : beat counter is on the last beat
//     miss_recovery_mode          : a line transfer is in progress
//     perform_write               : write the data array (store hit or fill beat)
//     set/clear_selected_dirty_bit, clear_selected_valid_bit : metadata updates
//     finish_new_line_install     : last fill beat, the line becomes valid
//     set_hmem_block_address      : latch the higher-memory line address
//     use_victim_tag_for_hmem_block_address : use the victim tag, not the request tag
//     reset_counter, decrement_counter      : beat counter controls
// ---------------------------------------------------------------------------
module cache_controller #(
  parameter int WORDS_PER_LINE = 8,
  parameter bit READ_ONLY      = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  cache_controller_if.slave  bus,
  input  logic               valid_block_match,
  input  logic               valid_dirty_bit,
  input  logic               counter_done,
  output logic               miss_recovery_mode,
  output logic               perform_write,
  output logic               set_selected_dirty_bit,
  output logic               clear_selected_dirty_bit,
  output logic               clear_selected_valid_bit,
  output logic               finish_new_line_install,
  output logic               set_hmem_block_address,
  output logic               use_victim_tag_for_hmem_block_address,
  output logic               reset_counter,
  output logic               decrement_counter
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  localparam logic OP_LOAD   = 1'b0;
  localparam logic OP_STORE  = 1'b1;
  localparam bit   HAS_STORE = !READ_ONLY;

  state_t state;
  state_t state_next;

  // A read-only cache treats every request as a load. It never evicts
  // anything, because its lines can never be dirty.
  logic is_store;
  logic victim_dirty;
  logic beat_done;

  assign is_store     = HAS_STORE && bus.req_operation;
  assign victim_dirty = HAS_STORE && valid_dirty_bit;
  assign beat_done    = bus.hmem_req_fulfilled;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so that every flop samples
  // pre-edge values. Blocking assignments here would create order-dependent
  // races between always_ff blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block purely
  // combinational. Without it, any path that skips an assignment would infer
  // a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (!bus.req_valid)         state_next = IDLE;
        else if (valid_block_match) state_next = IDLE;
        else if (victim_dirty)      state_next = WRITEBACK;
        else                        state_next = ALLOCATE;
      end
      WRITEBACK: begin
        if (beat_done && counter_done) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        // Replay the lookup. The freshly installed line makes it hit, or it
        // falls back to IDLE if the requester has gone away meanwhile.
        if (beat_done && counter_done) state_next = LOOKUP;
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode (Moore terms from state, Mealy terms from status inputs)
  // -------------------------------------------------------------------------
  always_comb begin
    bus.req_fulfilled                     = 1'b0;
    bus.hmem_req_valid                    = 1'b0;
    bus.hmem_req_operation                = OP_LOAD;
    miss_recovery_mode                    = 1'b0;
    perform_write                         = 1'b0;
    set_selected_dirty_bit                = 1'b0;
    clear_selected_dirty_bit              = 1'b0;
    clear_selected_valid_bit              = 1'b0;
    finish_new_line_install               = 1'b0;
    set_hmem_block_address                = 1'b0;
    use_victim_tag_for_hmem_block_address = 1'b0;
    reset_counter                         = 1'b0;
    decrement_counter                     = 1'b0;

    case (state)
      IDLE: ;

      LOOKUP: begin
        if (bus.req_valid) begin
          if (valid_block_match) begin
            bus.req_fulfilled = 1'b1;
            if (is_store) begin
              perform_write          = 1'b1;
              set_selected_dirty_bit = 1'b1;
            end
          end else begin
            set_hmem_block_address = 1'b1;
            reset_counter          = 1'b1;
            if (victim_dirty) begin
              // The victim's address goes out first for the writeback.
              use_victim_tag_for_hmem_block_address = 1'b1;
            end else begin
              // A clean victim is simply dropped while the fill overwrites it.
              clear_selected_valid_bit = 1'b1;
            end
          end
        end
      end

      WRITEBACK: begin
        if (HAS_STORE) begin
          miss_recovery_mode     = 1'b1;
          bus.hmem_req_valid     = 1'b1;
          bus.hmem_req_operation = OP_STORE;
          if (beat_done) begin
            if (counter_done) begin
              // The victim is now safe in higher memory. Invalidate it and
              // point the address at the requested line for the fill.
              clear_selected_dirty_bit = 1'b1;
              clear_selected_valid_bit = 1'b1;
              set_hmem_block_address   = 1'b1;
              reset_counter            = 1'b1;
            end else begin
              decrement_counter = 1'b1;
            end
          end
        end
      end

      ALLOCATE: begin
        miss_recovery_mode     = 1'b1;
        bus.hmem_req_valid     = 1'b1;
        bus.hmem_req_operation = OP_LOAD;
        if (beat_done) begin
          perform_write = 1'b1;
          if (counter_done) finish_new_line_install = 1'b1;
          else              decrement_counter       = 1'b1;
        end
      end

      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Protocol checks
  // -------------------------------------------------------------------------
  // Shadow beat index within the current line transfer. Only the alignment
  // assertion below reads it. It confirms that the datapath counter reports
  // done on exactly the WORDS_PER_LINE-th beat.
  localparam int BEAT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  logic [BEAT_W-1:0] beat_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count <= '0;
    end else if (reset_counter) begin
      beat_count <= '0;
    end else if (decrement_counter) begin
      beat_count <= beat_count + 1'b1;
    end
  end

  a_beat_align: assert property (@(posedge clk) disable iff (reset)
    (bus.hmem_req_valid && beat_done) |-> (counter_done == (beat_count == LAST_BEAT)));

  a_fulfil_pulse: assert property (@(posedge clk) disable iff (reset)
    bus.req_fulfilled |=> !bus.req_fulfilled);

  a_fulfil_in_lookup: assert property (@(posedge clk) disable iff (reset)
    bus.req_fulfilled |-> (state == LOOKUP));

  a_no_store_beat_ro: assert property (@(posedge clk) disable iff (reset)
    !(READ_ONLY && bus.hmem_req_valid && bus.hmem_req_operation));

endmodule

// File: tb/tb_cache_controller.sv
// ---------------------------------------------------------------------------
// tb_cache_controller
//   Self-checking bench for cache_controller. A read/write instance and a
//   read-only instance share one stimulus set. Only the selected instance
//   sees req_valid, so the other one stays idle.
//
//   The reference model works on transactions. From the request kind, the
//   victim state and a pre-drawn hmem_req_fulfilled pattern, it predicts the
//   cycle of every line-transfer beat, the beat direction, the fill writes,
//   the counter decrements and the completion cycle. It also predicts how
//   many times each metadata strobe fires. A small datapath model supplies
//   counter_done and the post-install hit.
// ---------------------------------------------------------------------------
module tb_cache_controller;

  localparam int WPL  = 8;
  localparam int MAXC = 256;

  // Bit positions in the collected output vector.
  localparam int B_FUL  = 0;
  localparam int B_HV   = 1;
  localparam int B_HOP  = 2;
  localparam int B_MISS = 3;
  localparam int B_PW   = 4;
  localparam int B_SD   = 5;
  localparam int B_CD   = 6;
  localparam int B_CV   = 7;
  localparam int B_FIN  = 8;
  localparam int B_SH   = 9;
  localparam int B_UV   = 10;
  localparam int B_RC   = 11;
  localparam int B_DC   = 12;
  localparam logic [12:0] TRACE_MASK = 13'b1_0001_0001_1111;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_operation, hmem_ful, vbm, vdb, cdone, sel_ro;

  always #5 clk = ~clk;

  cache_controller_if bus_rw ();
  cache_controller_if bus_ro ();

  assign bus_rw.req_valid          = req_valid & ~sel_ro;
  assign bus_ro.req_valid          = req_valid & sel_ro;
  assign bus_rw.req_operation      = req_operation;
  assign bus_ro.req_operation      = req_operation;
  assign bus_rw.hmem_req_fulfilled = hmem_ful;
  assign bus_ro.hmem_req_fulfilled = hmem_ful;

  logic rw_miss, rw_pw, rw_sd, rw_cd, rw_cv, rw_fin, rw_sh, rw_uv, rw_rc, rw_dc;
  logic ro_miss, ro_pw, ro_sd, ro_cd, ro_cv, ro_fin, ro_sh, ro_uv, ro_rc, ro_dc;
  logic [12:0] o_rw, o_ro, o_sel;

  cache_controller #(.WORDS_PER_LINE(WPL), .READ_ONLY(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus_rw),
    .valid_block_match(vbm), .valid_dirty_bit(vdb), .counter_done(cdone),
    .miss_recovery_mode(rw_miss), .perform_write(rw_pw),
    .set_selected_dirty_bit(rw_sd), .clear_selected_dirty_bit(rw_cd),
    .clear_selected_valid_bit(rw_cv), .finish_new_line_install(rw_fin),
    .set_hmem_block_address(rw_sh), .use_victim_tag_for_hmem_block_address(rw_uv),
    .reset_counter(rw_rc), .decrement_counter(rw_dc)
  );

  cache_controller #(.WORDS_PER_LINE(WPL), .READ_ONLY(1'b1)) dut_ro (
    .clk(clk), .reset(reset), .bus(bus_ro),
    .valid_block_match(vbm), .valid_dirty_bit(vdb), .counter_done(cdone),
    .miss_recovery_mode(ro_miss), .perform_write(ro_pw),
    .set_selected_dirty_bit(ro_sd), .clear_selected_dirty_bit(ro_cd),
    .clear_selected_valid_bit(ro_cv), .finish_new_line_install(ro_fin),
    .set_hmem_block_address(ro_sh), .use_victim_tag_for_hmem_block_address(ro_uv),
    .reset_counter(ro_rc), .decrement_counter(ro_dc)
  );

  assign o_rw = {rw_dc, rw_rc, rw_uv, rw_sh, rw_fin, rw_cv, rw_cd, rw_sd, rw_pw, rw_miss,
                 bus_rw.hmem_req_operation, bus_rw.hmem_req_valid, bus_rw.req_fulfilled};
  assign o_ro = {ro_dc, ro_rc, ro_uv, ro_sh, ro_fin, ro_cv, ro_cd, ro_sd, ro_pw, ro_miss,
                 bus_ro.hmem_req_operation, bus_ro.hmem_req_valid, bus_ro.req_fulfilled};
  assign o_sel = sel_ro ? o_ro : o_rw;

  int checks = 0;
  int errors = 0;

  // One request from idle to idle. ful_mode: 100 = fulfil every cycle,
  // -1 = fulfil every other cycle, otherwise the percent chance per cycle.
  // drop_cycle: 0 = the requester holds until fulfilled, else req_valid
  // falls in that cycle.
  task automatic run_txn(input bit ro, input bit op, input bit hit, input bit dirty,
                         input int ful_mode, input int drop_cycle, input string name);
    bit fp [MAXC];
    bit wb, eff_store, live, did_ful, store_phase, last_beat, installed, seen_ful;
    int nbeats, ones, e, ful_at, last_c, k, beat, cnt;
    int trace_bad, first_bad, ful_count, ful_cycle;
    int n_sd, n_cd, n_cv, n_sh, n_uv, n_rc;
    int x_sd, x_cd, x_cv, x_sh, x_uv, x_rc;
    logic [12:0] exp_v, obs, bad_obs, bad_exp;

    wb        = !hit && dirty && !ro;
    eff_store = op && !ro;
    live      = (drop_cycle == 0) || (drop_cycle > 2);
    nbeats    = hit ? 0 : (wb ? 2 * WPL : WPL);

    // Pre-draw the higher-memory fulfil pattern. The transfer can start no
    // earlier than cycle 3, and beat N lands on the N-th set bit from there.
    ones = 0;
    e    = 2;
    for (int c = 0; c < MAXC; c++) begin
      if (ful_mode == 100)     fp[c] = 1'b1;
      else if (ful_mode == -1) fp[c] = ((c % 2) == 1);
      else                     fp[c] = ($urandom_range(0, 99) < ful_mode) || (c > 150);
      if (c >= 3 && ones < nbeats && fp[c]) begin
        ones++;
        if (ones == nbeats) e = c;
      end
    end
    ful_at  = hit ? 2 : e + 1;
    did_ful = live && ((drop_cycle == 0) || (drop_cycle > ful_at));
    last_c  = (live ? ful_at : 2) + 2;

    x_sd = (did_ful && eff_store) ? 1 : 0;
    x_uv = (live && wb) ? 1 : 0;
    x_cd = (live && wb) ? 1 : 0;
    x_cv = (live && !hit) ? 1 : 0;
    x_sh = (live && !hit) ? (wb ? 2 : 1) : 0;
    x_rc = x_sh;

    sel_ro = ro;
    installed = 1'b0; seen_ful = 1'b0; cnt = 0; k = 0;
    trace_bad = 0; first_bad = 0; ful_count = 0; ful_cycle = 0;
    n_sd = 0; n_cd = 0; n_cv = 0; n_sh = 0; n_uv = 0; n_rc = 0;
    bad_obs = '0; bad_exp = '0;

    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      req_valid     = !seen_ful && ((drop_cycle == 0) || (c < drop_cycle));
      req_operation = op;
      vbm           = hit || installed;
      vdb           = dirty;
      cdone         = (cnt == 0);
      hmem_ful      = fp[c];
      #1;
      obs = o_sel;

      exp_v = '0;
      if (live && c == ful_at) begin
        exp_v[B_FUL] = did_ful;
        exp_v[B_PW]  = did_ful && eff_store;
      end else if (live && !hit && c >= 3 && c <= e) begin
        store_phase   = wb && (k < WPL);
        exp_v[B_HV]   = 1'b1;
        exp_v[B_MISS] = 1'b1;
        exp_v[B_HOP]  = store_phase;
        if (fp[c]) begin
          beat          = store_phase ? k : (wb ? k - WPL : k);
          last_beat     = (beat == WPL - 1);
          exp_v[B_DC]   = !last_beat;
          exp_v[B_PW]   = !store_phase;
          exp_v[B_FIN]  = !store_phase && last_beat;
        end
      end

      if ((obs & TRACE_MASK) !== exp_v) begin
        trace_bad++;
        if (first_bad == 0) begin
          first_bad = c; bad_obs = obs & TRACE_MASK; bad_exp = exp_v;
        end
      end

      if (obs[B_FUL]) begin ful_count++; ful_cycle = c; seen_ful = 1'b1; end
      n_sd += int'(obs[B_SD]); n_cd += int'(obs[B_CD]); n_cv += int'(obs[B_CV]);
      n_sh += int'(obs[B_SH]); n_uv += int'(obs[B_UV]); n_rc += int'(obs[B_RC]);

      // Datapath side effects that take hold at the coming clock edge.
      if (obs[B_RC])      cnt = WPL - 1;
      else if (obs[B_DC]) cnt = cnt - 1;
      if (obs[B_FIN])     installed = 1'b1;
      if (c >= 3 && fp[c]) k++;
    end
    req_valid = 1'b0;
    hmem_ful  = 1'b0;

    checks++;
    if (trace_bad !== 0) begin
      errors++;
      $display("FAIL %s trace: %0d bad cycles, first at cycle %0d got %b required %b",
               name, trace_bad, first_bad, bad_obs, bad_exp);
    end
    checks++;
    if (ful_count !== (did_ful ? 1 : 0) || ful_cycle !== (did_ful ? ful_at : 0)) begin
      errors++;
      $display("FAIL %s fulfil: count %0d at cycle %0d, required count %0d at cycle %0d",
               name, ful_count, ful_cycle, did_ful ? 1 : 0, did_ful ? ful_at : 0);
    end
    checks++;
    if (n_sd !== x_sd || n_cd !== x_cd || n_cv !== x_cv) begin
      errors++;
      $display("FAIL %s dirty/valid strobes: set_dirty=%0d clr_dirty=%0d clr_valid=%0d, required %0d %0d %0d",
               name, n_sd, n_cd, n_cv, x_sd, x_cd, x_cv);
    end
    checks++;
    if (n_sh !== x_sh || n_uv !== x_uv || n_rc !== x_rc) begin
      errors++;
      $display("FAIL %s address/counter strobes: set_addr=%0d victim=%0d rst_cnt=%0d, required %0d %0d %0d",
               name, n_sh, n_uv, n_rc, x_sh, x_uv, x_rc);
    end
  endtask

  task automatic test_reset();
    sel_ro = 1'b0; reset = 1'b1;
    req_valid = 1'b1; req_operation = 1'b0; vbm = 1'b1; vdb = 1'b1; cdone = 1'b0; hmem_ful = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (o_rw !== 13'b0 || o_ro !== 13'b0) begin
        errors++;
        $display("FAIL reset_hold: rw=%b ro=%b required all zero", o_rw, o_ro);
      end
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (o_rw !== 13'b0) begin
      errors++;
      $display("FAIL reset_release: rw=%b required all zero", o_rw);
    end
    @(negedge clk); #1;
    checks++;
    if (o_rw !== (13'b1 << B_FUL)) begin
      errors++;
      $display("FAIL reset_first_hit: rw=%b required %b", o_rw, 13'b1 << B_FUL);
    end
    req_valid = 1'b0; hmem_ful = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (o_rw !== 13'b0) begin
      errors++;
      $display("FAIL reset_back_idle: rw=%b required all zero", o_rw);
    end
  endtask

  task automatic test_load_hit();
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 100, 0, "load_hit");
    run_txn(1'b0, 1'b0, 1'b1, 1'b1, 100, 0, "load_hit_dirty_line");
  endtask

  task automatic test_store_hit();
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 100, 0, "store_hit");
  endtask

  task automatic test_clean_miss();
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 100, 0, "clean_load_miss");
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 50, 0, "clean_store_miss_stall");
  endtask

  task automatic test_dirty_miss();
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, -1, 0, "dirty_store_miss_alt");
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 100, 0, "dirty_load_miss");
  endtask

  task automatic test_request_drop();
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 100, 2, "drop_in_lookup");
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, 100, 5, "drop_mid_transfer");
  endtask

  task automatic test_reset_mid_allocate();
    int cnt;
    int hv_seen;
    sel_ro = 1'b0; req_operation = 1'b0; vbm = 1'b0; vdb = 1'b0; cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = 1'b1; cdone = (cnt == 0); hmem_ful = 1'b1;
      #1;
      if (o_rw[B_RC])      cnt = WPL - 1;
      else if (o_rw[B_DC]) cnt = cnt - 1;
    end
    // Cycle 6 carries the fourth ALLOCATE beat.
    checks++;
    if (o_rw[B_HV] !== 1'b1 || o_rw[B_HOP] !== 1'b0 || o_rw[B_DC] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_beat4: hv=%b op=%b dec=%b required 1 0 1",
               o_rw[B_HV], o_rw[B_HOP], o_rw[B_DC]);
    end
    reset = 1'b1; req_valid = 1'b0; #1;
    checks++;
    if (o_rw !== 13'b0) begin
      errors++;
      $display("FAIL reset_mid_immediate: rw=%b required all zero", o_rw);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0; #1;
    checks++;
    if (o_rw !== 13'b0) begin
      errors++;
      $display("FAIL reset_mid_release: rw=%b required all zero", o_rw);
    end
    hv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); hmem_ful = 1'b1; #1;
      hv_seen += int'(o_rw[B_HV]);
    end
    hmem_ful = 1'b0;
    checks++;
    if (hv_seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_resume: hmem_req_valid cycles %0d required 0", hv_seen);
    end
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 100, 0, "restart_hit");
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 100, 0, "restart_miss");
  endtask

  task automatic test_read_only();
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, 100, 0, "ro_dirty_load_miss");
    run_txn(1'b1, 1'b1, 1'b0, 1'b1, -1, 0, "ro_dirty_store_miss");
    run_txn(1'b1, 1'b1, 1'b1, 1'b1, 100, 0, "ro_store_hit");
  endtask

  task automatic test_random();
    int mode_sel;
    int mode;
    int drop;
    bit hit;
    for (int i = 0; i < 24; i++) begin
      mode_sel = $urandom_range(0, 2);
      mode = (mode_sel == 0) ? 100 : ((mode_sel == 1) ? -1 : $urandom_range(25, 90));
      hit  = $urandom_range(0, 1);
      drop = ($urandom_range(0, 7) == 0) ? (hit ? 2 : 5) : 0;
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hit,
              1'($urandom_range(0, 1)), mode, drop, "random");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_hit();
    test_store_hit();
    test_clean_miss();
    test_dirty_miss();
    test_request_drop();
    test_reset_mid_allocate();
    test_read_only();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
